score_board: RTL

Parametrised BCD score keeper with a sorted on-chip high-score table and a registered display selector feeding the seven-segment `HexDriver` instances. It sits between the `frogger` game core (score events, game-over commits) and the hex display path, replacing the single running score / single high-score register and its switch-selected display mux. Table insertion is a multi-cycle state machine so a wide table never creates a long comparator/shift chain in one cycle.

---
 rtl/score_board.sv | 115 +++++++++++
 1 files changed

// File: rtl/score_board.sv
// score_board: BCD live score, sorted high-score table with multi-cycle insertion, registered display select.
// Define SCORE_BOARD_SATURATE_EN to saturate the live score at all-9s instead of wrapping.
module score_board #(
    parameter int DIGITS = 4,
    parameter int DEPTH  = 4,
    parameter int VIEW_W = $clog2(DEPTH + 1)
) (
    input  logic                Clk,
    input  logic                Reset,
    input  logic [3:0]          add_val,
    input  logic                add_en,
    input  logic                clr_score,
    input  logic                commit,
    input  logic [VIEW_W-1:0]   view_sel,
    output logic [4*DIGITS-1:0] score,
    output logic [4*DIGITS-1:0] disp,
    output logic                disp_is_table,
    output logic                busy,
    output logic                new_record
);
    localparam int W  = 4 * DIGITS;
    localparam int IW = DEPTH > 1 ? $clog2(DEPTH) : 1;
    typedef enum logic [1:0] {IDLE, SCAN, SHIFT, WRITE} state_t;
    state_t        state_q, state_d;
    logic [W-1:0]  score_q, score_d, cand_q, cand_d, disp_q, disp_d, sum, sat;
    logic [W-1:0]  tbl_q [DEPTH];
    logic [IW-1:0] idx_q, idx_d, ins_q, ins_d;
    logic          dit_q, dit_d, nr_q, carry, take;
    logic [4:0]    t;
    logic [3:0]    addv;
    assign addv = add_val > 4'd9 ? 4'd9 : add_val;
    assign take = commit && state_q == IDLE;
    always_comb begin
        sum   = '0;
        carry = 1'b0;
        t     = '0;
        for (int i = 0; i < DIGITS; i++) begin
            t     = {1'b0, score_q[4*i +: 4]} + {1'b0, (i == 0) ? addv : 4'd0} + {4'd0, carry};
            carry = t > 5'd9;
            sum[4*i +: 4] = carry ? t[3:0] - 4'd10 : t[3:0];
        end
    end
`ifdef SCORE_BOARD_SATURATE_EN
    assign sat = carry ? {DIGITS{4'd9}} : sum;
`else
    assign sat = sum;
`endif
    assign score_d = (take || clr_score) ? '0 : add_en ? sat : score_q;
    // BCD packing preserves ordering, so a plain binary compare ranks scores
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        ins_d   = ins_q;
        cand_d  = cand_q;
        case (state_q)
            IDLE: if (commit) begin
                cand_d  = score_q;
                idx_d   = '0;
                state_d = SCAN;
            end
            SCAN: if (cand_q > tbl_q[idx_q]) begin
                ins_d   = idx_q;
                idx_d   = IW'(DEPTH - 1);
                state_d = idx_q == IW'(DEPTH - 1) ? WRITE : SHIFT;
            end else begin
                idx_d   = idx_q + 1'b1;
                state_d = idx_q == IW'(DEPTH - 1) ? IDLE : SCAN;
            end
            SHIFT: begin
                idx_d   = idx_q - 1'b1;
                state_d = idx_q == ins_q + 1'b1 ? WRITE : SHIFT;
            end
            default: state_d = IDLE;
        endcase
    end
    always_comb begin
        disp_d = view_sel == '0 ? score_q : '0;
        dit_d  = 1'b0;
        for (int k = 0; k < DEPTH; k++) begin
            if (view_sel == VIEW_W'(k + 1)) begin
                disp_d = tbl_q[k];
                dit_d  = 1'b1;
            end
        end
    end
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q <= IDLE;
            idx_q   <= '0;
            ins_q   <= '0;
            cand_q  <= '0;
            score_q <= '0;
            disp_q  <= '0;
            dit_q   <= 1'b0;
            nr_q    <= 1'b0;
            for (int k = 0; k < DEPTH; k++) tbl_q[k] <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            ins_q   <= ins_d;
            cand_q  <= cand_d;
            score_q <= score_d;
            disp_q  <= disp_d;
            dit_q   <= dit_d;
            nr_q    <= state_q == WRITE && ins_q == '0;
            if (state_q == SHIFT) tbl_q[idx_q] <= tbl_q[idx_q - 1'b1];
            if (state_q == WRITE) tbl_q[ins_q] <= cand_q;
        end
    end
    assign score         = score_q;
    assign disp          = disp_q;
    assign disp_is_table = dit_q;
    assign busy          = state_q != IDLE;
    assign new_record    = nr_q;
endmodule
